// File: rtl/decode_stage.sv
// Decode stage: input FIFO, stale-tag drop, decode into my_pkg fields.
// Optional macro DECODE_ILLEGAL_TRAP_EN passes illegal instructions through flagged.
package my_pkg;
    typedef enum logic [2:0] {
        XU_BYPASS  = 3'd0,
        XU_ADDER   = 3'd1,
        XU_LOGICAL = 3'd2,
        XU_SHIFTER = 3'd3,
        XU_BRANCH  = 3'd4,
        XU_MEMORY  = 3'd5
    } xu_t;
    typedef enum logic [2:0] {
        R_type = 3'd0,
        I_type = 3'd1,
        S_type = 3'd2,
        B_type = 3'd3,
        U_type = 3'd4,
        J_type = 3'd5
    } fmts_t;
    typedef enum logic [2:0] {
        OP0, OP1, OP2, OP3, OP4, OP5, OP6, OP7
    } instruction_type_t;
    typedef struct packed {
        instruction_type_t i;
        xu_t               xu;
        fmts_t             fmt;
        logic              illegal;
    } dec_t;
endpackage

module decode_stage
    import my_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [31:0]      instruction_in,
    input  logic [31:0]      NPC_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             jump,
    input  logic [TAG_W-1:0] jump_tag,
    input  logic             hold,
    output logic             valid_out,
    output logic [31:0]      instruction,
    output logic [31:0]      NPC,
    output logic [2:0]       i,
    output logic [2:0]       xu_sel,
    output logic [2:0]       fmt,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]      ins_mem [DEPTH];
    logic [31:0]      npc_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TAG_W-1:0] cur_q, cur_d;
    logic             enq, deq, load;
    logic [31:0]      hd_ins;
    logic [6:0]       op, f7;
    logic [2:0]       f3;
    dec_t             dec;

    logic             v_q;
    logic [31:0]      ins_q, npc_q;
    logic [2:0]       i_q, xu_q, fmt_q;
    logic [TAG_W-1:0] tag_q;

    function automatic dec_t mk(xu_t x, fmts_t f, instruction_type_t t);
        dec_t d;
        d.xu = x;
        d.fmt = f;
        d.i = t;
        d.illegal = 1'b0;
        return d;
    endfunction

    assign ready_out = (cnt_q < CW'(DEPTH));
    assign enq = valid_in && ready_out && !(jump && (tag_in != jump_tag));
    assign deq = !hold && (cnt_q != '0);
    assign hd_ins = ins_mem[rd_q];
    assign op = hd_ins[6:0];
    assign f3 = hd_ins[14:12];
    assign f7 = hd_ins[31:25];

    // Opcode/funct decode of the FIFO head
    always_comb begin
        dec = '0;
        unique case (op)
            7'b0110011: begin
                unique case (1'b1)
                    (f3 == 3'd0 && f7 == 7'h00): dec = mk(XU_ADDER, R_type, OP0);
                    (f3 == 3'd0 && f7 == 7'h20): dec = mk(XU_ADDER, R_type, OP1);
                    (f3 == 3'd2 && f7 == 7'h00): dec = mk(XU_ADDER, R_type, OP2);
                    (f3 == 3'd3 && f7 == 7'h00): dec = mk(XU_ADDER, R_type, OP3);
                    (f3 == 3'd4 && f7 == 7'h00): dec = mk(XU_LOGICAL, R_type, OP0);
                    (f3 == 3'd6 && f7 == 7'h00): dec = mk(XU_LOGICAL, R_type, OP1);
                    (f3 == 3'd7 && f7 == 7'h00): dec = mk(XU_LOGICAL, R_type, OP2);
                    (f3 == 3'd1 && f7 == 7'h00): dec = mk(XU_SHIFTER, R_type, OP0);
                    (f3 == 3'd5 && f7 == 7'h00): dec = mk(XU_SHIFTER, R_type, OP1);
                    (f3 == 3'd5 && f7 == 7'h20): dec = mk(XU_SHIFTER, R_type, OP2);
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                unique case (1'b1)
                    (f3 == 3'd0): dec = mk(XU_ADDER, I_type, OP0);
                    (f3 == 3'd2): dec = mk(XU_ADDER, I_type, OP2);
                    (f3 == 3'd3): dec = mk(XU_ADDER, I_type, OP3);
                    (f3 == 3'd4): dec = mk(XU_LOGICAL, I_type, OP0);
                    (f3 == 3'd6): dec = mk(XU_LOGICAL, I_type, OP1);
                    (f3 == 3'd7): dec = mk(XU_LOGICAL, I_type, OP2);
                    (f3 == 3'd1 && f7 == 7'h00): dec = mk(XU_SHIFTER, I_type, OP0);
                    (f3 == 3'd5 && f7 == 7'h00): dec = mk(XU_SHIFTER, I_type, OP1);
                    (f3 == 3'd5 && f7 == 7'h20): dec = mk(XU_SHIFTER, I_type, OP2);
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                unique case (f3)
                    3'd0: dec = mk(XU_MEMORY, I_type, OP0);
                    3'd4: dec = mk(XU_MEMORY, I_type, OP1);
                    3'd1: dec = mk(XU_MEMORY, I_type, OP2);
                    3'd5: dec = mk(XU_MEMORY, I_type, OP3);
                    3'd2: dec = mk(XU_MEMORY, I_type, OP4);
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                unique case (f3)
                    3'd0: dec = mk(XU_MEMORY, S_type, OP5);
                    3'd1: dec = mk(XU_MEMORY, S_type, OP6);
                    3'd2: dec = mk(XU_MEMORY, S_type, OP7);
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b1100011: begin
                unique case (f3)
                    3'd0: dec = mk(XU_BRANCH, B_type, OP0);
                    3'd1: dec = mk(XU_BRANCH, B_type, OP1);
                    3'd4: dec = mk(XU_BRANCH, B_type, OP2);
                    3'd5: dec = mk(XU_BRANCH, B_type, OP3);
                    3'd6: dec = mk(XU_BRANCH, B_type, OP4);
                    3'd7: dec = mk(XU_BRANCH, B_type, OP5);
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b1101111: dec = mk(XU_BRANCH, J_type, OP6);
            7'b1100111: begin
                if (f3 == 3'd0) dec = mk(XU_BRANCH, I_type, OP7);
                else dec.illegal = 1'b1;
            end
            7'b0110111: dec = mk(XU_BYPASS, U_type, OP0);
            7'b0010111: dec = mk(XU_ADDER, U_type, OP4);
            default: dec.illegal = 1'b1;
        endcase
    end

    // A popped head reaches the outputs only with a current tag
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign load = deq && !jump && (tag_mem[rd_q] == cur_q);
`else
    assign load = deq && !jump && (tag_mem[rd_q] == cur_q) && !dec.illegal;
`endif

    // FIFO pointer, count and current-tag next state; jump flushes all
    always_comb begin
        wr_d = enq ? wr_q + 1'b1 : wr_q;
        rd_d = rd_q;
        cnt_d = cnt_q;
        cur_d = cur_q;
        if (jump) begin
            rd_d = wr_q;
            cnt_d = enq ? CW'(1) : '0;
            cur_d = jump_tag;
        end else begin
            if (deq) rd_d = rd_q + 1'b1;
            unique case ({enq, deq})
                2'b10: cnt_d = cnt_q + 1'b1;
                2'b01: cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            cur_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            cur_q <= cur_d;
        end
    end

    // FIFO storage, written on enqueue
    always_ff @(posedge clk) begin
        if (enq) begin
            ins_mem[wr_q] <= instruction_in;
            npc_mem[wr_q] <= NPC_in;
            tag_mem[wr_q] <= tag_in;
        end
    end

    // Output bundle: frozen on hold, else decoded head or bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= 1'b0;
            ins_q <= '0;
            npc_q <= '0;
            i_q <= '0;
            xu_q <= '0;
            fmt_q <= '0;
            tag_q <= '0;
        end else if (!hold) begin
            v_q <= load;
            ins_q <= load ? hd_ins : '0;
            npc_q <= load ? npc_mem[rd_q] : '0;
            i_q <= load ? dec.i : '0;
            xu_q <= load ? dec.xu : '0;
            fmt_q <= load ? dec.fmt : '0;
            tag_q <= load ? tag_mem[rd_q] : '0;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic ill_q;

    // Illegal flag travels with the output bundle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ill_q <= 1'b0;
        else if (!hold) ill_q <= load && dec.illegal;
    end

    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

    assign valid_out = v_q;
    assign instruction = ins_q;
    assign NPC = npc_q;
    assign i = i_q;
    assign xu_sel = xu_q;
    assign fmt = fmt_q;
    assign tag_out = tag_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, hold, jump, reset.
// Expected values are hand-derived from the instruction encodings.
module tb_decode_stage;
    import my_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] instruction_in;
    logic [31:0] NPC_in;
    logic [3:0]  tag_in;
    logic        jump;
    logic [3:0]  jump_tag;
    logic        hold;
    logic        valid_out;
    logic [31:0] instruction;
    logic [31:0] NPC;
    logic [2:0]  i;
    logic [2:0]  xu_sel;
    logic [2:0]  fmt;
    logic [3:0]  tag_out;
    logic        illegal;

    int checks;
    int errs;

    logic [31:0] tv_ins [5];
    logic [2:0]  tv_xu  [5];
    logic [2:0]  tv_fmt [5];
    logic [2:0]  tv_i   [5];

    always #5 clk = ~clk;

    decode_stage #(.DEPTH(2), .TAG_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .instruction_in(instruction_in),
        .NPC_in(NPC_in),
        .tag_in(tag_in),
        .jump(jump),
        .jump_tag(jump_tag),
        .hold(hold),
        .valid_out(valid_out),
        .instruction(instruction),
        .NPC(NPC),
        .i(i),
        .xu_sel(xu_sel),
        .fmt(fmt),
        .tag_out(tag_out),
        .illegal(illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [3:0] tg);
        valid_in = v;
        instruction_in = ins;
        NPC_in = pc;
        tag_in = tg;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v,
                           input logic [31:0] ins, input logic [31:0] pc,
                           input logic [2:0] x, input logic [2:0] f,
                           input logic [2:0] t, input logic [3:0] tg,
                           input logic il);
        chk({nm, ".valid"}, {31'b0, valid_out}, {31'b0, v});
        chk({nm, ".ins"}, instruction, ins);
        chk({nm, ".npc"}, NPC, pc);
        chk({nm, ".xu"}, {29'b0, xu_sel}, {29'b0, x});
        chk({nm, ".fmt"}, {29'b0, fmt}, {29'b0, f});
        chk({nm, ".i"}, {29'b0, i}, {29'b0, t});
        chk({nm, ".tag"}, {28'b0, tag_out}, {28'b0, tg});
        chk({nm, ".ill"}, {31'b0, illegal}, {31'b0, il});
    endtask

    task automatic chk_bub(input string nm);
        chk_out(nm, 1'b0, 32'h0, 32'h0, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errs = 0;
        reset = 1'b0;
        jump = 1'b0;
        jump_tag = 4'd0;
        hold = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tv_ins[0] = 32'h00209463; tv_xu[0] = 3'd4;
        tv_fmt[0] = B_type; tv_i[0] = 3'd1;
        tv_ins[1] = 32'h008000EF; tv_xu[1] = 3'd4;
        tv_fmt[1] = J_type; tv_i[1] = 3'd6;
        tv_ins[2] = 32'h00001197; tv_xu[2] = 3'd1;
        tv_fmt[2] = U_type; tv_i[2] = 3'd4;
        tv_ins[3] = 32'h4020D1B3; tv_xu[3] = 3'd3;
        tv_fmt[3] = R_type; tv_i[3] = 3'd2;
        tv_ins[4] = 32'h0000D183; tv_xu[4] = 3'd5;
        tv_fmt[4] = I_type; tv_i[4] = 3'd3;

        tick();
        tick();
        chk_bub("rst");
        chk("rst.rdy", {31'b0, ready_out}, 32'd1);
        reset = 1'b1;
        tick();

        drv(1'b1, 32'h00510093, 32'h100, 4'd0);
        tick();
        chk("addi.lat", {31'b0, valid_out}, 32'd0);
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
        chk_out("addi", 1'b1, 32'h00510093, 32'h100, 3'd1, I_type, 3'd0, 4'd0, 1'b0);

        drv(1'b1, 32'h00112223, 32'h104, 4'd0);
        tick();
        drv(1'b1, 32'h00012083, 32'h108, 4'd0);
        tick();
        chk_out("sw", 1'b1, 32'h00112223, 32'h104, 3'd5, S_type, 3'd7, 4'd0, 1'b0);
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
        chk_out("lw", 1'b1, 32'h00012083, 32'h108, 3'd5, I_type, 3'd4, 4'd0, 1'b0);
        tick();
        chk("lw.after", {31'b0, valid_out}, 32'd0);

        drv(1'b1, 32'h0FF0E193, 32'h200, 4'd0);
        tick();
        drv(1'b1, 32'h002081B3, 32'h204, 4'd0);
        tick();
        chk_out("ori", 1'b1, 32'h0FF0E193, 32'h200, 3'd2, I_type, 3'd1, 4'd0, 1'b0);
        hold = 1'b1;
        drv(1'b1, 32'h402081B3, 32'h208, 4'd0);
        chk("hold.rdy1", {31'b0, ready_out}, 32'd1);
        tick();
        chk("hold.rdy0", {31'b0, ready_out}, 32'd0);
        drv(1'b1, 32'h0020C1B3, 32'h20C, 4'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold.full", {31'b0, ready_out}, 32'd0);
            chk_out("hold.frz", 1'b1, 32'h0FF0E193, 32'h200, 3'd2, I_type, 3'd1, 4'd0, 1'b0);
        end
        hold = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
        chk_out("add", 1'b1, 32'h002081B3, 32'h204, 3'd1, R_type, 3'd0, 4'd0, 1'b0);
        chk("add.rdy", {31'b0, ready_out}, 32'd1);
        tick();
        chk_out("sub", 1'b1, 32'h402081B3, 32'h208, 3'd1, R_type, 3'd1, 4'd0, 1'b0);
        tick();
        chk("hold.nodup", {31'b0, valid_out}, 32'd0);

        hold = 1'b1;
        drv(1'b1, 32'h00309193, 32'h300, 4'd0);
        tick();
        drv(1'b1, 32'h00209193, 32'h304, 4'd0);
        tick();
        chk("jq.full", {31'b0, ready_out}, 32'd0);
        hold = 1'b0;
        jump = 1'b1;
        jump_tag = 4'd1;
        drv(1'b1, 32'h00510093, 32'h308, 4'd0);
        tick();
        jump = 1'b0;
        chk_bub("jmp");
        chk("jmp.rdy", {31'b0, ready_out}, 32'd1);
        drv(1'b1, 32'h00510093, 32'h30C, 4'd0);
        tick();
        drv(1'b1, 32'h4030D193, 32'h310, 4'd1);
        tick();
        chk("jmp.stale", {31'b0, valid_out}, 32'd0);
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
        chk_out("srai", 1'b1, 32'h4030D193, 32'h310, 3'd3, I_type, 3'd2, 4'd1, 1'b0);
        tick();
        chk("srai.after", {31'b0, valid_out}, 32'd0);

        jump = 1'b1;
        jump_tag = 4'd2;
        drv(1'b1, 32'h123451B7, 32'h400, 4'd2);
        tick();
        chk("jc.bub", {31'b0, valid_out}, 32'd0);
        jump = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
        chk_out("lui", 1'b1, 32'h123451B7, 32'h400, 3'd0, U_type, 3'd0, 4'd2, 1'b0);
        jump = 1'b1;
        jump_tag = 4'd3;
        drv(1'b1, 32'h123451B7, 32'h404, 4'd2);
        tick();
        jump = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
        chk("jc.drop", {31'b0, valid_out}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            if (k < 5) drv(1'b1, tv_ins[k], 32'h500 + 32'(4 * k), 4'd3);
            else drv(1'b0, 32'h0, 32'h0, 4'd0);
            tick();
            if (k > 0)
                chk_out("tbl", 1'b1, tv_ins[k-1], 32'h500 + 32'(4 * (k - 1)),
                        tv_xu[k-1], tv_fmt[k-1], tv_i[k-1], 4'd3, 1'b0);
        end

        drv(1'b1, 32'hFFFFFFFF, 32'h600, 4'd3);
        tick();
        drv(1'b1, 32'hFE0081B3, 32'h604, 4'd3);
        tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk_out("ill", 1'b1, 32'hFFFFFFFF, 32'h600, 3'd0, R_type, 3'd0, 4'd3, 1'b1);
`else
        chk_bub("ill");
`endif
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk_out("illf7", 1'b1, 32'hFE0081B3, 32'h604, 3'd0, R_type, 3'd0, 4'd3, 1'b1);
`else
        chk_bub("illf7");
`endif

        drv(1'b1, 32'h00510093, 32'h700, 4'd3);
        tick();
        drv(1'b1, 32'h00112223, 32'h704, 4'd3);
        tick();
        chk("pre.valid", {31'b0, valid_out}, 32'd1);
        hold = 1'b1;
        drv(1'b1, 32'h00012083, 32'h708, 4'd3);
        tick();
        chk("pre.full", {31'b0, ready_out}, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk_bub("rst2");
        chk("rst2.rdy", {31'b0, ready_out}, 32'd1);
        hold = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst2.empty", {31'b0, valid_out}, 32'd0);
        end
        drv(1'b1, 32'h00510093, 32'h800, 4'd0);
        tick();
        drv(1'b0, 32'h0, 32'h0, 4'd0);
        tick();
        chk_out("post", 1'b1, 32'h00510093, 32'h800, 3'd1, I_type, 3'd0, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
